// File: rtl/bcd_down_counter.sv
// Synchronous multi-digit BCD down counter with clamped preset load and a
// combinational terminal-count borrow for cascading stages.
module bcd_down_counter #(
  parameter int DIGITS = 2,
  parameter int WRAP   = 1
) (
  input  logic                  Clk,
  input  logic                  Clr,
  input  logic                  En,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   D,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  Zero,
  output logic                  Borrow
);

  logic [4*DIGITS-1:0] q_next;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [3:0] dec_digit(input logic [3:0] d);
    return (d == 4'd0) ? 4'd9 : d - 4'd1;
  endfunction

  assign Zero   = (Q == '0);
  assign Borrow = En & ~Load & Zero;

  // A digit steps only when every digit below it is zero; at all-zero every
  // digit steps, which yields all nines unless wrapping is disabled.
  always_comb begin
    logic step;
    step   = 1'b1;
    q_next = Q;
    for (int i = 0; i < DIGITS; i++) begin
      if (Load) begin
        q_next[4*i +: 4] = clamp_digit(D[4*i +: 4]);
      end else if (En && !(Zero && (WRAP == 0))) begin
        if (step) q_next[4*i +: 4] = dec_digit(Q[4*i +: 4]);
      end
      step = step & (Q[4*i +: 4] == 4'd0);
    end
  end

  // Stage 0: count register
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) Q <= '0;
    else      Q <= q_next;
  end

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed self-checking bench for bcd_down_counter: wrapping and holding
// two-digit instances plus a cascade of two single-digit stages.
module tb_bcd_down_counter;

  logic       clk = 1'b0;
  logic       clr;
  logic       en, load;
  logic [7:0] d;
  logic [7:0] q_w, q_h;
  logic       zero_w, zero_h, borrow_w, borrow_h;

  logic       c_en, c_load;
  logic [3:0] d_lo, d_hi, q_lo, q_hi;
  logic       zero_lo, zero_hi, borrow_lo, borrow_hi;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_down_counter #(.DIGITS(2), .WRAP(1)) u_wrap (
    .Clk(clk), .Clr(clr), .En(en), .Load(load), .D(d),
    .Q(q_w), .Zero(zero_w), .Borrow(borrow_w)
  );

  bcd_down_counter #(.DIGITS(2), .WRAP(0)) u_hold (
    .Clk(clk), .Clr(clr), .En(en), .Load(load), .D(d),
    .Q(q_h), .Zero(zero_h), .Borrow(borrow_h)
  );

  bcd_down_counter #(.DIGITS(1), .WRAP(1)) u_lo (
    .Clk(clk), .Clr(clr), .En(c_en), .Load(c_load), .D(d_lo),
    .Q(q_lo), .Zero(zero_lo), .Borrow(borrow_lo)
  );

  bcd_down_counter #(.DIGITS(1), .WRAP(1)) u_hi (
    .Clk(clk), .Clr(clr), .En(borrow_lo), .Load(c_load), .D(d_hi),
    .Q(q_hi), .Zero(zero_hi), .Borrow(borrow_hi)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_val(input logic [7:0] v);
    load = 1'b1; en = 1'b0; d = v;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b0; en = 1'b0; load = 1'b0; d = 8'h00;
    c_en = 1'b0; c_load = 1'b0; d_lo = 4'h0; d_hi = 4'h0;
    tick();
    checks++;
    if (q_w !== 8'h00 || zero_w !== 1'b1) begin
      errors++; $display("FAIL reset_state q=%h zero=%b expected q=00 zero=1", q_w, zero_w);
    end
    clr = 1'b1;
    load_val(8'h37);
    checks++;
    if (q_w !== 8'h37) begin
      errors++; $display("FAIL preload_37 q=%h expected 37", q_w);
    end
    // Assert reset between edges with En high
    en = 1'b1;
    #2 clr = 1'b0;
    #1;
    checks++;
    if (q_w !== 8'h00 || zero_w !== 1'b1 || borrow_w !== 1'b1) begin
      errors++; $display("FAIL async_clear q=%h zero=%b borrow=%b expected 00 1 1", q_w, zero_w, borrow_w);
    end
    en = 1'b0;
    #1;
    checks++;
    if (borrow_w !== 1'b0) begin
      errors++; $display("FAIL reset_borrow_en_low borrow=%b expected 0", borrow_w);
    end
    tick();
    clr = 1'b1;
    tick();
    checks++;
    if (q_w !== 8'h00) begin
      errors++; $display("FAIL hold_after_reset q=%h expected 00", q_w);
    end
  endtask

  task automatic test_decrement();
    logic [7:0] exp_seq [5];
    exp_seq = '{8'h41, 8'h40, 8'h39, 8'h38, 8'h37};
    load_val(8'h42);
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (q_w !== exp_seq[i]) begin
        errors++; $display("FAIL decrement_step%0d q=%h expected %h", i, q_w, exp_seq[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_terminal();
    logic [7:0] exp_w [3];
    exp_w = '{8'h00, 8'h99, 8'h98};
    load_val(8'h01);
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (q_w !== exp_w[i]) begin
        errors++; $display("FAIL wrap_step%0d q=%h expected %h", i, q_w, exp_w[i]);
      end
      if (i == 0) begin
        checks++;
        if (borrow_w !== 1'b1) begin
          errors++; $display("FAIL wrap_borrow borrow=%b expected 1", borrow_w);
        end
      end
      if (i < 2) begin
        checks++;
        if (q_h !== 8'h00 || borrow_h !== 1'b1) begin
          errors++; $display("FAIL hold_zero_step%0d q=%h borrow=%b expected 00 1", i, q_h, borrow_h);
        end
      end
    end
    en = 1'b0;
    #1;
    checks++;
    if (borrow_h !== 1'b0) begin
      errors++; $display("FAIL hold_borrow_en_low borrow=%b expected 0", borrow_h);
    end
  endtask

  task automatic test_load_clamp();
    load = 1'b1; en = 1'b1; d = 8'h5C;
    tick();
    checks++;
    if (q_w !== 8'h59) begin
      errors++; $display("FAIL load_clamp_lo q=%h expected 59", q_w);
    end
    load = 1'b0;
    tick();
    checks++;
    if (q_w !== 8'h58) begin
      errors++; $display("FAIL after_clamp_dec q=%h expected 58", q_w);
    end
    en = 1'b0;
    load_val(8'hF3);
    checks++;
    if (q_w !== 8'h93) begin
      errors++; $display("FAIL load_clamp_hi q=%h expected 93", q_w);
    end
  endtask

  task automatic test_en_toggle();
    logic [7:0] exp_q [3];
    logic       en_seq [3];
    exp_q  = '{8'h09, 8'h09, 8'h08};
    en_seq = '{1'b1, 1'b0, 1'b1};
    load_val(8'h10);
    for (int i = 0; i < 3; i++) begin
      en = en_seq[i];
      tick();
      checks++;
      if (q_w !== exp_q[i]) begin
        errors++; $display("FAIL toggle_step%0d q=%h expected %h", i, q_w, exp_q[i]);
      end
      if (!en_seq[i]) begin
        checks++;
        if (borrow_w !== 1'b0) begin
          errors++; $display("FAIL toggle_borrow borrow=%b expected 0", borrow_w);
        end
      end
    end
    en = 1'b0;
  endtask

  task automatic test_cascade();
    c_load = 1'b1; c_en = 1'b0; d_hi = 4'd2; d_lo = 4'd0;
    tick();
    c_load = 1'b0;
    checks++;
    if ({q_hi, q_lo} !== 8'h20) begin
      errors++; $display("FAIL cascade_load q=%h expected 20", {q_hi, q_lo});
    end
    c_en = 1'b1;
    #1;
    checks++;
    if (borrow_lo !== 1'b1) begin
      errors++; $display("FAIL cascade_borrow borrow=%b expected 1", borrow_lo);
    end
    tick();
    checks++;
    if ({q_hi, q_lo} !== 8'h19) begin
      errors++; $display("FAIL cascade_step q=%h expected 19", {q_hi, q_lo});
    end
    tick();
    checks++;
    if ({q_hi, q_lo} !== 8'h18) begin
      errors++; $display("FAIL cascade_step2 q=%h expected 18", {q_hi, q_lo});
    end
    c_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_decrement();
    test_terminal();
    test_load_clamp();
    test_en_toggle();
    test_cascade();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
